// File: rtl/cla_pkg.sv
// Shared constants and result bundle for the 4-bit carry-lookahead adder.
package cla_pkg;

   localparam int CLA_W = 4;

   typedef struct packed {
      logic             cout;
      logic [CLA_W-1:0] sum;
      logic             grp_p;
      logic             grp_g;
   } cla_result_t;

endpackage

// File: rtl/cla_lookahead_unit.sv
// Combinational 4-bit lookahead carry unit: every carry is a flat
// sum-of-products of p/g/c0, so no carry ever ripples through a lower bit.
module cla_lookahead_unit
   import cla_pkg::*;
(
   input  logic [CLA_W-1:0] p,
   input  logic [CLA_W-1:0] g,
   input  logic             c0,
   output logic [CLA_W:1]   c,
   output logic             grp_p,
   output logic             grp_g
);

   always_comb begin
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

      // Group terms exclude c0 so a second-level lookahead can chain them.
      grp_p = p[3] & p[2] & p[1] & p[0];
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
   end

endmodule

// File: rtl/cla_adder_4bit.sv
// Registered 4-bit carry-lookahead adder with one-cycle latency and
// group propagate/generate outputs for hierarchical lookahead.
module cla_adder_4bit
   import cla_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [CLA_W-1:0] in1,
   input  logic [CLA_W-1:0] in2,
   input  logic             cin,
   output logic [CLA_W-1:0] sum,
   output logic             cout,
   output logic             out_valid,
   output logic             grp_p,
   output logic             grp_g
);

   logic [CLA_W-1:0] p;
   logic [CLA_W-1:0] g;
   logic [CLA_W:1]   c;
   logic             grp_p_c;
   logic             grp_g_c;

   cla_result_t      res_d;
   cla_result_t      res_q;
   logic             valid_d;
   logic             valid_q;

   cla_lookahead_unit u_lookahead (
      .p     (p),
      .g     (g),
      .c0    (cin),
      .c     (c),
      .grp_p (grp_p_c),
      .grp_g (grp_g_c)
   );

   // Idle cycles select the held value, so garbage on the data inputs
   // never reaches the result register.
   always_comb begin
      p       = in1 ^ in2;
      g       = in1 & in2;
      res_d   = res_q;
      valid_d = in_valid;
      if (in_valid) begin
         res_d.cout  = c[4];
         res_d.sum   = p ^ {c[3:1], cin};
         res_d.grp_p = grp_p_c;
         res_d.grp_g = grp_g_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
      end
   end

   assign sum       = res_q.sum;
   assign cout      = res_q.cout;
   assign grp_p     = res_q.grp_p;
   assign grp_g     = res_q.grp_g;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_cla_adder_4bit.sv
// Self-checking bench for cla_adder_4bit against an arithmetic reference model.
module tb_cla_adder_4bit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in1;
   logic [3:0] in2;
   logic       cin;
   logic [3:0] sum;
   logic       cout;
   logic       out_valid;
   logic       grp_p;
   logic       grp_g;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_sum;
   logic       exp_cout;
   logic       exp_p;
   logic       exp_g;
   logic       exp_valid;

   cla_adder_4bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in1       (in1),
      .in2       (in2),
      .cin       (cin),
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid),
      .grp_p     (grp_p),
      .grp_g     (grp_g)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: plain integer addition; group generate is "a+b alone
   // overflows", group propagate is "a+b is all ones".
   task automatic modelAdd(input logic [3:0] a, input logic [3:0] b, input logic ci);
      logic [4:0] total;
      logic [4:0] ab;
      total     = {1'b0, a} + {1'b0, b} + {4'b0, ci};
      ab        = {1'b0, a} + {1'b0, b};
      exp_sum   = total[3:0];
      exp_cout  = total[4];
      exp_g     = (ab > 5'd15);
      exp_p     = (ab == 5'd15) && ((a & b) == 4'h0);
   endtask

   task automatic modelReset();
      exp_sum   = 4'h0;
      exp_cout  = 1'b0;
      exp_p     = 1'b0;
      exp_g     = 1'b0;
      exp_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                input logic ci, input logic v);
      @(negedge clk);
      in1      = a;
      in2      = b;
      cin      = ci;
      in_valid = v;
      @(posedge clk);
      if (rst_n) begin
         if (v) modelAdd(a, b, ci);
         exp_valid = v;
      end else begin
         modelReset();
      end
      #1;
   endtask

   task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput(input string tag);
      cmp({tag, ".sum"},       sum,                expv_sum());
      cmp({tag, ".cout"},      {3'b0, cout},       {3'b0, exp_cout});
      cmp({tag, ".grp_p"},     {3'b0, grp_p},      {3'b0, exp_p});
      cmp({tag, ".grp_g"},     {3'b0, grp_g},      {3'b0, exp_g});
      cmp({tag, ".out_valid"}, {3'b0, out_valid},  {3'b0, exp_valid});
   endtask

   function automatic logic [3:0] expv_sum();
      return exp_sum;
   endfunction

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in1      = 4'h0;
      in2      = 4'h0;
      cin      = 1'b0;
      modelReset();

      // Reset held with random valid traffic: outputs stay cleared.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
         checkOutput("reset_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors.
      applyStimulus(4'b1010, 4'b0100, 1'b0, 1'b1);
      checkOutput("dir_1010_0100");
      applyStimulus(4'b1110, 4'b1001, 1'b0, 1'b1);
      checkOutput("dir_1110_1001");
      applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b1);
      checkOutput("dir_1111_1111_c1");
      applyStimulus(4'b1101, 4'b1010, 1'b1, 1'b1);
      checkOutput("dir_1101_1010_c1");
      applyStimulus(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
      checkOutput("idle_hold_x");
      applyStimulus(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      checkOutput("idle_hold_rand");
      applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1);
      checkOutput("full_propagate");

      // Asynchronous reset mid-cycle: outputs clear before any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("async_reset");

      // Valid operand presented during reset is discarded.
      applyStimulus(4'b0111, 4'b0111, 1'b1, 1'b1);
      checkOutput("reset_discard");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(4'b0011, 4'b0101, 1'b0, 1'b1);
      checkOutput("first_after_reset");

      // Exhaustive back-to-back sweep.
      for (int k = 0; k < 512; k++) begin
         applyStimulus(4'(k >> 5), 4'(k >> 1), 1'(k), 1'b1);
         checkOutput("sweep");
      end

      // Random traffic with random gaps.
      for (int i = 0; i < 200; i++) begin
         applyStimulus(4'($urandom), 4'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0));
         checkOutput("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
